// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the single-cycle core.
// Request sequencer states and the latched data-access bundle.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DATA  = 2'd1,
    HALT  = 2'd2
  } reqstate_t;

  typedef struct packed {
    logic  ren;
    logic  wen;
    logic  atom;
    word_t addr;
    word_t store;
  } dreq_t;

endpackage

// File: rtl/mem_request_unit_if.sv
// Control-unit / cache side signals of the memory request unit.
// master: the request unit; slave: control unit and caches.
interface mem_request_unit_if;
  import cpu_types_pkg::*;

  logic  cu_dREN;
  logic  cu_dWEN;
  logic  cu_halt;
  logic  cu_datomic;
  word_t cu_daddr;
  word_t cu_dstore;
  logic  ihit;
  logic  dhit;
  logic  imemREN;
  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  pc_en;
  logic  wen_ok;
  logic  halt;
  word_t sc_result;

  modport master (
    input  cu_dREN, cu_dWEN, cu_halt, cu_datomic,
    input  cu_daddr, cu_dstore, ihit, dhit,
    output imemREN, dmemREN, dmemWEN,
    output dmemaddr, dmemstore,
    output pc_en, wen_ok, halt, sc_result
  );

  modport slave (
    output cu_dREN, cu_dWEN, cu_halt, cu_datomic,
    output cu_daddr, cu_dstore, ihit, dhit,
    input  imemREN, dmemREN, dmemWEN,
    input  dmemaddr, dmemstore,
    input  pc_en, wen_ok, halt, sc_result
  );

endinterface

// File: rtl/mem_request_unit_link_reg.sv
// LL/SC link register: holds the reserved address and its valid bit.
// Only built when REQ_ATOMIC_EN is defined.
`ifdef REQ_ATOMIC_EN
module link_reg
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  set_i,
  input  logic  clr_i,
  input  word_t addr_i,
  output logic  hit_o
);

  logic  valid_q, valid_d;
  word_t addr_q, addr_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (set_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign hit_o = valid_q && (addr_q == addr_i);

endmodule
`endif

// File: rtl/mem_request_unit.sv
// Memory request sequencer: fetch, held data access, commit pulse, halt.
// Define REQ_ATOMIC_EN to build the LL/SC link register.
module mem_request_unit
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  mem_request_unit_if.master bus,
  output logic [CNT_W-1:0] stall_cnt
);

  reqstate_t        state_q, state_d;
  dreq_t            req_q, req_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic imem, dren, dwen;
  logic commit, data_commit, stall;
  logic atom_in, link_hit;
  logic sc_op, sc_fail;

`ifdef REQ_ATOMIC_EN
  logic link_set, link_clr;

  assign atom_in  = bus.cu_datomic;
  assign link_set = data_commit & bus.dhit
                  & req_q.ren & req_q.atom;
  assign link_clr = data_commit & req_q.wen
                  & (req_q.atom | (bus.dhit & link_hit));

  link_reg u_link (
    .CLK    (CLK),
    .nRST   (nRST),
    .set_i  (link_set),
    .clr_i  (link_clr),
    .addr_i (req_q.addr),
    .hit_o  (link_hit)
  );
`else
  logic unused_atom;

  assign unused_atom = bus.cu_datomic;
  assign atom_in     = 1'b0;
  assign link_hit    = 1'b0;
`endif

  // A failing SC never writes and retires without waiting for dhit.
  assign sc_op   = req_q.wen & req_q.atom;
  assign sc_fail = sc_op & ~link_hit;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    halt_d      = halt_q;
    imem        = 1'b0;
    dren        = 1'b0;
    dwen        = 1'b0;
    commit      = 1'b0;
    data_commit = 1'b0;
    stall       = 1'b0;
    unique case (state_q)
      FETCH: begin
        imem  = 1'b1;
        stall = ~bus.ihit;
        if (bus.ihit) begin
          if (bus.cu_halt) begin
            state_d = HALT;
            halt_d  = 1'b1;
          end else if (bus.cu_dREN | bus.cu_dWEN) begin
            req_d.ren   = bus.cu_dREN;
            req_d.wen   = bus.cu_dWEN;
            req_d.atom  = atom_in;
            req_d.addr  = bus.cu_daddr;
            req_d.store = bus.cu_dstore;
            state_d     = DATA;
          end else begin
            commit = 1'b1;
          end
        end
      end
      DATA: begin
        dren        = req_q.ren;
        dwen        = req_q.wen & ~sc_fail;
        stall       = ~bus.dhit;
        commit      = bus.dhit | sc_fail;
        data_commit = commit;
        if (commit) state_d = FETCH;
      end
      HALT: begin
      end
      default: state_d = FETCH;
    endcase
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FETCH;
      req_q   <= '0;
      halt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      halt_q  <= halt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gate combinational outputs so nothing leaks out while in reset.
  assign bus.imemREN   = imem & nRST;
  assign bus.dmemREN   = dren & nRST;
  assign bus.dmemWEN   = dwen & nRST;
  assign bus.pc_en     = commit & nRST;
  assign bus.wen_ok    = commit & nRST;
  assign bus.halt      = halt_q;
  assign bus.dmemaddr  = req_q.addr;
  assign bus.dmemstore = req_q.store;
  assign bus.sc_result = {31'b0,
    data_commit & sc_op & link_hit & nRST};
  assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_mem_request_unit.sv
// Randomized self-checking bench for mem_request_unit.
// Reference model tracks pending access, halt, link and stall count.
module tb_mem_request_unit;
  import cpu_types_pkg::*;

  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;
`ifdef REQ_ATOMIC_EN
  localparam bit ATOM = 1'b1;
`else
  localparam bit ATOM = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          nRST;
  logic [CW-1:0] stall_cnt;

  mem_request_unit_if bus();

  mem_request_unit #(.CNT_W(CW)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  always #5 CLK = ~CLK;

  int vecs = 0;
  int errs = 0;

  bit    m_busy, m_halted, m_lv;
  word_t m_la;
  bit    r_ren, r_wen, r_atom;
  word_t r_addr, r_data;
  int    m_cnt;
  bit    e_stall, e_commit;
  logic [109:0] exp_v;

  function automatic logic [109:0] obs();
    return {bus.imemREN, bus.dmemREN, bus.dmemWEN,
            bus.pc_en, bus.wen_ok, bus.halt,
            bus.sc_result, bus.dmemaddr,
            bus.dmemstore, stall_cnt};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_halted = 0; m_lv = 0; m_la = '0;
    r_ren = 0; r_wen = 0; r_atom = 0;
    r_addr = '0; r_data = '0; m_cnt = 0;
    e_stall = 0; e_commit = 0;
  endtask

  task automatic model_eval();
    bit im, dr, dw, cm, scr, sc, ok;
    im = 0; dr = 0; dw = 0; cm = 0; scr = 0;
    e_stall = 0;
    e_commit = 0;
    if (!nRST) begin
      exp_v = '0;
      return;
    end
    if (!m_halted && !m_busy) begin
      im = 1;
      e_stall = !bus.ihit;
      cm = bus.ihit && !bus.cu_halt
           && !(bus.cu_dREN || bus.cu_dWEN);
    end else if (m_busy) begin
      sc  = r_wen && r_atom;
      ok  = sc && m_lv && (m_la == r_addr);
      dr  = r_ren;
      dw  = r_wen && !(sc && !ok);
      cm  = bus.dhit || (sc && !ok);
      scr = cm && ok;
      e_stall = !bus.dhit;
    end
    e_commit = cm;
    exp_v = {im, dr, dw, cm, cm, m_halted,
             {31'b0, scr}, r_addr, r_data, CW'(m_cnt)};
  endtask

  task automatic model_update();
    if (!nRST) begin
      model_reset();
      return;
    end
    if (e_stall && m_cnt < CMAX) m_cnt++;
    if (m_busy && e_commit) begin
      if (r_ren && r_atom && bus.dhit) begin
        m_lv = 1;
        m_la = r_addr;
      end else if (r_wen && r_atom) begin
        m_lv = 0;
      end else if (r_wen && bus.dhit && r_addr == m_la) begin
        m_lv = 0;
      end
      m_busy = 0;
    end else if (!m_busy && !m_halted && bus.ihit) begin
      if (bus.cu_halt) begin
        m_halted = 1;
      end else if (bus.cu_dREN || bus.cu_dWEN) begin
        m_busy = 1;
        r_ren  = bus.cu_dREN;
        r_wen  = bus.cu_dWEN;
        r_atom = ATOM && bus.cu_datomic;
        r_addr = bus.cu_daddr;
        r_data = bus.cu_dstore;
      end
    end
  endtask

  task automatic cycle(input bit ih, input bit dh,
                       input bit rn, input bit wn,
                       input bit hl, input bit at,
                       input word_t a, input word_t d);
    @(posedge CLK);
    model_update();
    #1;
    bus.ihit = ih; bus.dhit = dh;
    bus.cu_dREN = rn; bus.cu_dWEN = wn;
    bus.cu_halt = hl; bus.cu_datomic = at;
    bus.cu_daddr = a; bus.cu_dstore = d;
    @(negedge CLK);
    model_eval();
  endtask

  task automatic reset_assert();
    nRST = 1'b0;
    bus.ihit = 0; bus.dhit = 0;
    bus.cu_dREN = 0; bus.cu_dWEN = 0;
    bus.cu_halt = 0; bus.cu_datomic = 0;
    bus.cu_daddr = '0; bus.cu_dstore = '0;
    model_reset();
    #1;
    model_eval();
  endtask

  task automatic reset_release();
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    model_eval();
  endtask

  task automatic test_reset();
    reset_assert();
    if (obs() !== exp_v || bus.imemREN !== 1'b0) begin
      errs++;
      $display("FAIL reset: got %h want %h", obs(), exp_v);
    end
    vecs++;
    bus.ihit = 1'b1;
    @(posedge CLK);
    #1;
    model_eval();
    if (obs() !== exp_v) begin
      errs++;
      $display("FAIL reset_ihit: got %h want %h", obs(), exp_v);
    end
    vecs++;
    reset_release();
    cycle(0, 0, 0, 0, 0, 0, '0, '0);
    if (obs() !== exp_v || bus.imemREN !== 1'b1) begin
      errs++;
      $display("FAIL reset_exit: got %h want %h", obs(), exp_v);
    end
    vecs++;
  endtask

  task automatic test_fetch();
    for (int i = 0; i < 10; i++) begin
      cycle(1, $urandom_range(0, 1), 0, 0, 0, 0,
            $urandom, $urandom);
      if (obs() !== exp_v) begin
        errs++;
        $display("FAIL fetch %0d: got %h want %h", i, obs(), exp_v);
      end
      vecs++;
    end
  endtask

  task automatic test_load();
    cycle(1, 0, 1, 0, 0, 0, 32'h100, $urandom);
    for (int i = 0; i < 5; i++) begin
      cycle(0, i == 3, 0, 0, 0, 0, $urandom, $urandom);
      if (obs() !== exp_v) begin
        errs++;
        $display("FAIL load %0d: got %h want %h", i, obs(), exp_v);
      end
      vecs++;
    end
  endtask

  task automatic test_store_change();
    cycle(1, 0, 0, 1, 0, 0, 32'h340, 32'hcafe_f00d);
    for (int i = 0; i < 5; i++) begin
      cycle($urandom_range(0, 1), i == 2, $urandom_range(0, 1),
            1, 0, 0, $urandom, $urandom);
      if (obs() !== exp_v) begin
        errs++;
        $display("FAIL store %0d: got %h want %h", i, obs(), exp_v);
      end
      vecs++;
    end
  endtask

  task automatic test_halt();
    cycle(1, 1, 0, 1, 1, 0, 32'h80, 32'h1234);
    for (int i = 0; i < 6; i++) begin
      cycle($urandom_range(0, 1), $urandom_range(0, 1),
            0, 1, $urandom_range(0, 1), 0, $urandom, $urandom);
      if (obs() !== exp_v || bus.dmemWEN !== 1'b0) begin
        errs++;
        $display("FAIL halt %0d: got %h want %h", i, obs(), exp_v);
      end
      vecs++;
    end
    reset_assert();
    reset_release();
  endtask

  task automatic test_atomic();
    bit [3:0] seq [6];
    seq = '{4'b1010, 4'b0110, 4'b1010, 4'b0100,
            4'b0110, 4'b0000};
    for (int k = 0; k < 6; k++) begin
      cycle(1, 0, seq[k][3], seq[k][2], 0, seq[k][1],
            32'h200, 32'h5a5a_0000 + k);
      for (int i = 0; i < 3; i++) begin
        cycle(0, i == 1, 0, 0, 0, 0, $urandom, $urandom);
        if (obs() !== exp_v) begin
          errs++;
          $display("FAIL atomic %0d.%0d: got %h want %h",
                   k, i, obs(), exp_v);
        end
        vecs++;
      end
    end
  endtask

  task automatic test_reset_mid_data();
    cycle(1, 0, 1, 0, 0, 0, 32'h44, '0);
    cycle(0, 0, 0, 0, 0, 0, '0, '0);
    cycle(0, 0, 0, 0, 0, 0, '0, '0);
    bus.dhit = 1'b1;
    reset_assert();
    if (obs() !== exp_v || bus.dmemREN !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset: got %h want %h", obs(), exp_v);
    end
    vecs++;
    reset_release();
    cycle(0, 1, 0, 0, 0, 0, '0, '0);
    if (obs() !== exp_v) begin
      errs++;
      $display("FAIL mid_reset_exit: got %h want %h", obs(), exp_v);
    end
    vecs++;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < CMAX + 20; i++) begin
      cycle(0, 0, 0, 0, 0, 0, '0, '0);
      if (obs() !== exp_v) begin
        errs++;
        $display("FAIL sat %0d: got %h want %h", i, obs(), exp_v);
      end
      vecs++;
    end
    if (stall_cnt !== CW'(CMAX)) begin
      errs++;
      $display("FAIL sat_max: got %0d want %0d", stall_cnt, CMAX);
    end
    vecs++;
  endtask

  task automatic test_random();
    word_t pool [3];
    bit rn, wn;
    pool = '{32'h200, 32'h204, 32'h100};
    reset_assert();
    reset_release();
    for (int i = 0; i < 500; i++) begin
      rn = $urandom_range(0, 2) == 0;
      wn = !rn && $urandom_range(0, 1) == 0;
      cycle($urandom_range(0, 1), $urandom_range(0, 4) < 2,
            rn, wn, $urandom_range(0, 49) == 0,
            $urandom_range(0, 2) == 0,
            pool[$urandom_range(0, 2)], $urandom);
      if (obs() !== exp_v) begin
        errs++;
        $display("FAIL rand %0d: got %h want %h", i, obs(), exp_v);
      end
      vecs++;
      if (m_halted && $urandom_range(0, 3) == 0) begin
        reset_assert();
        reset_release();
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store_change();
    test_halt();
    test_atomic();
    test_reset_mid_data();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
